// File: rtl/multi_cycle_controller.sv
// multi_cycle_controller: control FSM for the multi-cycle RISC-V core.
// Steps the shared ALU, the unified memory port, the register file and the
// PC/IR latches through IF, ID, EX, MEM, WB and an absorbing HALT state.
// Optional feature macro: MC_PERF_COUNTERS_EN adds cycle/retired counters.
//
// Handshake: a memory request (mem_read or mem_write, never both) is held
// with a stable i_or_d until the cycle i_mem_ready=1; that cycle completes
// the access. i_mem_ready is ignored outside IF and MEM.
module multi_cycle_controller (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [6:0]  i_opcode,
  input  logic        i_bcond,
  input  logic        i_ecall_halt,
  input  logic        i_mem_ready,
  output logic        o_pc_write,
  output logic        o_ir_write,
  output logic        o_i_or_d,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic        o_reg_write,
  output logic [1:0]  o_wb_sel,
  output logic        o_alu_src_a,
  output logic [1:0]  o_alu_src_b,
  output logic        o_alu_use_ctrl,
  output logic [1:0]  o_pc_source,
  output logic        o_illegal_inst,
  output logic        o_is_halted,
  output logic [31:0] o_cycle_count,
  output logic [31:0] o_retired_count,
  output logic [2:0]  o_dbg_state
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  state_t r_state;
  state_t w_next;

  logic       w_is_alu, w_is_load, w_is_store, w_is_branch;
  logic       w_is_jal, w_is_jalr, w_is_ecall, w_known;
  logic       w_enter_halt, w_retire;
  logic       w_pc_write, w_ir_write, w_i_or_d, w_mem_read, w_mem_write;
  logic       w_reg_write, w_alu_src_a, w_alu_use_ctrl, w_illegal, w_halted;
  logic [1:0] w_wb_sel, w_alu_src_b, w_pc_source;

  assign w_is_alu    = (i_opcode == OP_R) || (i_opcode == OP_I);
  assign w_is_load   = (i_opcode == OP_LOAD);
  assign w_is_store  = (i_opcode == OP_STORE);
  assign w_is_branch = (i_opcode == OP_BRANCH);
  assign w_is_jal    = (i_opcode == OP_JAL);
  assign w_is_jalr   = (i_opcode == OP_JALR);
  assign w_is_ecall  = (i_opcode == OP_ECALL);
  assign w_known     = w_is_alu | w_is_load | w_is_store | w_is_branch |
                       w_is_jal | w_is_jalr | w_is_ecall;

  // ECALL with the halt compare true retires on entry to HALT (no PC write)
  assign w_enter_halt = (r_state == S_ID) && w_is_ecall && i_ecall_halt;
  assign w_retire     = w_pc_write | w_enter_halt;

  // State register: asynchronous return to IF on reset
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= S_IF;
    else            r_state <= w_next;
  end

  // Next state and raw datapath controls from state, opcode, bcond and handshake
  always_comb begin
    w_next         = r_state;
    w_pc_write     = 1'b0;
    w_ir_write     = 1'b0;
    w_i_or_d       = 1'b0;
    w_mem_read     = 1'b0;
    w_mem_write    = 1'b0;
    w_reg_write    = 1'b0;
    w_wb_sel       = 2'b00;
    w_alu_src_a    = 1'b0;
    w_alu_src_b    = 2'b00;
    w_alu_use_ctrl = 1'b0;
    w_pc_source    = 2'b00;
    w_illegal      = 1'b0;
    w_halted       = 1'b0;
    case (r_state)
      S_IF: begin
        w_mem_read = 1'b1;
        if (i_mem_ready) begin
          w_ir_write = 1'b1;
          w_next     = S_ID;
        end
      end
      S_ID: begin
        // PC + imm goes into ALUOut for a later branch/JAL target
        w_alu_src_b = 2'b01;
        if (w_is_ecall && i_ecall_halt) begin
          w_next = S_HALT;
        end else if (w_is_ecall || !w_known) begin
          w_illegal  = !w_known;
          w_pc_write = 1'b1;
          w_next     = S_IF;
        end else begin
          w_next = S_EX;
        end
      end
      S_EX: begin
        w_next = S_IF;
        if (w_is_alu) begin
          w_alu_src_a    = 1'b1;
          w_alu_src_b    = (i_opcode == OP_I) ? 2'b01 : 2'b00;
          w_alu_use_ctrl = 1'b1;
          w_next         = S_WB;
        end else if (w_is_load || w_is_store) begin
          w_alu_src_a = 1'b1;
          w_alu_src_b = 2'b01;
          w_next      = S_MEM;
        end else if (w_is_branch) begin
          w_alu_src_a    = 1'b1;
          w_alu_use_ctrl = 1'b1;
          w_pc_write     = 1'b1;
          w_pc_source    = i_bcond ? 2'b01 : 2'b00;
        end else if (w_is_jal) begin
          w_reg_write = 1'b1;
          w_wb_sel    = 2'b10;
          w_pc_write  = 1'b1;
          w_pc_source = 2'b01;
        end else if (w_is_jalr) begin
          w_alu_src_a = 1'b1;
          w_alu_src_b = 2'b01;
          w_reg_write = 1'b1;
          w_wb_sel    = 2'b10;
          w_pc_write  = 1'b1;
          w_pc_source = 2'b10;
        end
      end
      S_MEM: begin
        w_i_or_d    = 1'b1;
        w_mem_read  = w_is_load;
        w_mem_write = w_is_store;
        if (i_mem_ready) begin
          if (w_is_load) begin
            w_next = S_WB;
          end else begin
            w_pc_write = 1'b1;
            w_next     = S_IF;
          end
        end
      end
      S_WB: begin
        w_reg_write = 1'b1;
        w_wb_sel    = w_is_load ? 2'b01 : 2'b00;
        w_pc_write  = 1'b1;
        w_next      = S_IF;
      end
      S_HALT: begin
        w_halted = 1'b1;
      end
      default: begin
        w_next = S_IF;
      end
    endcase
  end

  // Force every output low while reset is held, including the fetch request
  always_comb begin
    o_pc_write     = i_reset_n & w_pc_write;
    o_ir_write     = i_reset_n & w_ir_write;
    o_i_or_d       = i_reset_n & w_i_or_d;
    o_mem_read     = i_reset_n & w_mem_read;
    o_mem_write    = i_reset_n & w_mem_write;
    o_reg_write    = i_reset_n & w_reg_write;
    o_wb_sel       = i_reset_n ? w_wb_sel : 2'b00;
    o_alu_src_a    = i_reset_n & w_alu_src_a;
    o_alu_src_b    = i_reset_n ? w_alu_src_b : 2'b00;
    o_alu_use_ctrl = i_reset_n & w_alu_use_ctrl;
    o_pc_source    = i_reset_n ? w_pc_source : 2'b00;
    o_illegal_inst = i_reset_n & w_illegal;
    o_is_halted    = i_reset_n & w_halted;
  end

  assign o_dbg_state = r_state;

`ifdef MC_PERF_COUNTERS_EN
  logic [31:0] r_cycle_count;
  logic [31:0] r_retired_count;

  // Performance counters: both freeze in HALT and wrap naturally
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cycle_count   <= 32'd0;
      r_retired_count <= 32'd0;
    end else if (r_state != S_HALT) begin
      r_cycle_count <= r_cycle_count + 32'd1;
      if (w_retire) r_retired_count <= r_retired_count + 32'd1;
    end
  end

  assign o_cycle_count   = r_cycle_count;
  assign o_retired_count = r_retired_count;
`else
  logic w_unused_retire;
  assign w_unused_retire = w_retire;
  assign o_cycle_count   = 32'd0;
  assign o_retired_count = 32'd0;
`endif

endmodule

// File: tb/tb_multi_cycle_controller.sv
// tb_multi_cycle_controller: directed bench for multi_cycle_controller.
// Each instruction is expanded from the control rules into a per-cycle list
// of expected control words plus the stimulus for that cycle; one process
// drives each cycle and compares the DUT against it.
module tb_multi_cycle_controller;

  localparam int W = 16;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BAD    = 7'h7F;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n = 1'b0;
  logic [6:0]  opcode = '0;
  logic        bcond = 1'b0;
  logic        ecall_halt = 1'b0;
  logic        mem_ready = 1'b0;
  logic        pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write;
  logic [1:0]  wb_sel, alu_src_b, pc_source;
  logic        alu_src_a, alu_use_ctrl, illegal_inst, is_halted;
  logic [31:0] cycle_count, retired_count;
  logic [2:0]  dbg_state;

  multi_cycle_controller dut (
    .i_clk          (clk),
    .i_reset_n      (reset_n),
    .i_opcode       (opcode),
    .i_bcond        (bcond),
    .i_ecall_halt   (ecall_halt),
    .i_mem_ready    (mem_ready),
    .o_pc_write     (pc_write),
    .o_ir_write     (ir_write),
    .o_i_or_d       (i_or_d),
    .o_mem_read     (mem_read),
    .o_mem_write    (mem_write),
    .o_reg_write    (reg_write),
    .o_wb_sel       (wb_sel),
    .o_alu_src_a    (alu_src_a),
    .o_alu_src_b    (alu_src_b),
    .o_alu_use_ctrl (alu_use_ctrl),
    .o_pc_source    (pc_source),
    .o_illegal_inst (illegal_inst),
    .o_is_halted    (is_halted),
    .o_cycle_count  (cycle_count),
    .o_retired_count(retired_count),
    .o_dbg_state    (dbg_state)
  );

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       alu_use_ctrl;
    logic [1:0] pc_source;
    logic       illegal;
    logic       halted;
  } ctl_t;

  logic [W-1:0] act_ctl;
  assign act_ctl = {pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write,
                    wb_sel, alu_src_a, alu_src_b, alu_use_ctrl, pc_source,
                    illegal_inst, is_halted};

  // rdy: 0/1 drive that value, 2 = don't care (random)
  typedef struct {
    int         rdy;
    logic [6:0] op;
    logic       bc;
    logic       eh;
    bit         ret;
    bit         live;
  } stim_t;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  stim_t        stim_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int m_cyc = 0;
  int m_ret = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int v);
`ifdef MC_PERF_COUNTERS_EN
    return 32'(v);
`else
    return 32'(v) & 32'd0;
`endif
  endfunction

  function automatic logic [6:0] rop();
    return 7'($urandom);
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  task automatic push(input ctl_t c, input int rdy, input logic [6:0] op,
                      input logic bc, input logic eh, input bit ret, input bit live);
    stim_t s;
    s.rdy = rdy; s.op = op; s.bc = bc; s.eh = eh; s.ret = ret; s.live = live;
    exp_q.push_back(c);
    stim_q.push_back(s);
  endtask

  // Expand one instruction into its cycles, from the control rules
  task automatic plan(input logic [6:0] op, input logic bc, input logic eh,
                      input int if_wait, input int mem_wait, input int halt_cycles);
    ctl_t c;
    bit is_alu, is_ls, is_ld, is_st, is_br, is_jal, is_jalr, is_ecall, known;
    is_ld    = (op == OP_LOAD);
    is_st    = (op == OP_STORE);
    is_ls    = is_ld || is_st;
    is_alu   = (op == OP_R) || (op == OP_I);
    is_br    = (op == OP_BRANCH);
    is_jal   = (op == OP_JAL);
    is_jalr  = (op == OP_JALR);
    is_ecall = (op == OP_ECALL);
    known    = is_alu || is_ls || is_br || is_jal || is_jalr || is_ecall;
    // fetch: read at PC, held through the wait cycles
    for (int k = 0; k < if_wait; k++) begin
      c = '0; c.mem_read = 1'b1;
      push(c, 0, rop(), rb(), rb(), 1'b0, 1'b1);
    end
    c = '0; c.mem_read = 1'b1; c.ir_write = 1'b1;
    push(c, 1, rop(), rb(), rb(), 1'b0, 1'b1);
    // decode
    c = '0; c.alu_src_b = 2'b01;
    if (is_ecall && eh) begin
      push(c, 2, op, rb(), 1'b1, 1'b1, 1'b1);
      for (int k = 0; k < halt_cycles; k++) begin
        c = '0; c.halted = 1'b1;
        push(c, 2, rop(), rb(), rb(), 1'b0, 1'b0);
      end
      return;
    end
    if (is_ecall || !known) begin
      c.pc_write = 1'b1; c.illegal = !known;
      push(c, 2, op, rb(), is_ecall ? 1'b0 : rb(), 1'b1, 1'b1);
      return;
    end
    push(c, 2, op, rb(), rb(), 1'b0, 1'b1);
    // execute
    c = '0;
    if (is_alu) begin
      c.alu_src_a = 1'b1; c.alu_src_b = (op == OP_I) ? 2'b01 : 2'b00; c.alu_use_ctrl = 1'b1;
    end else if (is_ls) begin
      c.alu_src_a = 1'b1; c.alu_src_b = 2'b01;
    end else if (is_br) begin
      c.alu_src_a = 1'b1; c.alu_use_ctrl = 1'b1; c.pc_write = 1'b1;
      c.pc_source = bc ? 2'b01 : 2'b00;
    end else if (is_jal) begin
      c.reg_write = 1'b1; c.wb_sel = 2'b10; c.pc_write = 1'b1; c.pc_source = 2'b01;
    end else begin
      c.alu_src_a = 1'b1; c.alu_src_b = 2'b01; c.reg_write = 1'b1; c.wb_sel = 2'b10;
      c.pc_write = 1'b1; c.pc_source = 2'b10;
    end
    push(c, 2, op, is_br ? bc : rb(), rb(), c.pc_write, 1'b1);
    if (is_br || is_jal || is_jalr) return;
    // memory access at ALUOut
    if (is_ls) begin
      for (int k = 0; k < mem_wait; k++) begin
        c = '0; c.i_or_d = 1'b1; c.mem_read = is_ld; c.mem_write = is_st;
        push(c, 0, op, rb(), rb(), 1'b0, 1'b1);
      end
      c = '0; c.i_or_d = 1'b1; c.mem_read = is_ld; c.mem_write = is_st; c.pc_write = is_st;
      push(c, 1, op, rb(), rb(), is_st, 1'b1);
      if (is_st) return;
    end
    // write-back
    c = '0; c.reg_write = 1'b1; c.wb_sel = is_ld ? 2'b01 : 2'b00; c.pc_write = 1'b1;
    push(c, 2, op, rb(), rb(), 1'b1, 1'b1);
  endtask

  // ---------------- driver + compare ----------------
  // Starts and ends on a falling edge; n < 0 runs everything queued
  task automatic run(input int n);
    int cnt;
    stim_t s;
    logic [W-1:0] e;
    cnt = (n < 0) ? exp_q.size() : n;
    for (int i = 0; i < cnt; i++) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      mem_ready  = (s.rdy == 2) ? rb() : s.rdy[0];
      opcode     = s.op;
      bcond      = s.bc;
      ecall_halt = s.eh;
      #1;
      check("ctl", 32'(act_ctl), 32'(e));
      check("mem_rw_exclusive", 32'(mem_read & mem_write), 32'd0);
      check("cycle_count", cycle_count, exp_cnt(m_cyc));
      check("retired_count", retired_count, exp_cnt(m_ret));
      m_cyc += int'(s.live);
      m_ret += int'(s.ret);
      @(negedge clk);
    end
  endtask

  // Assert reset (asynchronously, mid-cycle), hold it, release on a falling edge
  task automatic do_reset(input int n);
    reset_n   = 1'b0;
    mem_ready = 1'b1;
    opcode    = rop();
    #1;
    check("rst_ctl", 32'(act_ctl), 32'd0);
    check("rst_cycle_count", cycle_count, 32'd0);
    check("rst_retired_count", retired_count, 32'd0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mem_ready = rb();
      #1;
      check("rst_hold_ctl", 32'(act_ctl), 32'd0);
      check("rst_hold_mem_read", 32'(mem_read), 32'd0);
    end
    exp_q.delete();
    stim_q.delete();
    m_cyc = 0;
    m_ret = 0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    @(negedge clk);
    do_reset(3);

    // R-type ADD, zero-wait: IF, ID, EX, WB
    plan(OP_R, 1'b0, 1'b0, 0, 0, 0);
    check("len_add", 32'(exp_q.size()), 32'd4);
    run(-1);

    // I-type with a slow fetch
    plan(OP_I, 1'b0, 1'b0, 2, 0, 0);
    check("len_addi_if2", 32'(exp_q.size()), 32'd6);
    run(-1);

    // LOAD with three MEM wait cycles
    plan(OP_LOAD, 1'b0, 1'b0, 0, 3, 0);
    check("len_load_w3", 32'(exp_q.size()), 32'd8);
    run(-1);

    // STORE, zero-wait and with waits in both IF and MEM
    plan(OP_STORE, 1'b0, 1'b0, 0, 0, 0);
    check("len_store", 32'(exp_q.size()), 32'd4);
    run(-1);
    plan(OP_STORE, 1'b0, 1'b0, 1, 2, 0);
    run(-1);

    // Branches taken and not taken, then jumps
    plan(OP_BRANCH, 1'b1, 1'b0, 0, 0, 0);
    check("len_branch", 32'(exp_q.size()), 32'd3);
    run(-1);
    plan(OP_BRANCH, 1'b0, 1'b0, 0, 0, 0);
    run(-1);
    plan(OP_JAL, 1'b0, 1'b0, 0, 0, 0);
    run(-1);
    plan(OP_JALR, 1'b0, 1'b0, 1, 0, 0);
    run(-1);

    // Undefined opcodes become NOPs; ECALL without halt continues
    plan(OP_BAD, 1'b0, 1'b0, 0, 0, 0);
    check("len_illegal", 32'(exp_q.size()), 32'd2);
    run(-1);
    plan(OP_LUI, 1'b0, 1'b0, 0, 0, 0);
    run(-1);
    plan(OP_ECALL, 1'b0, 1'b0, 0, 0, 0);
    check("len_ecall", 32'(exp_q.size()), 32'd2);
    run(-1);
    plan(OP_R, 1'b0, 1'b0, 0, 0, 0);
    run(-1);

    // Reset in the middle of a STORE's memory wait
    plan(OP_STORE, 1'b0, 1'b0, 0, 3, 0);
    run(5);
    do_reset(2);
    plan(OP_R, 1'b0, 1'b0, 0, 0, 0);
    run(-1);
`ifdef MC_PERF_COUNTERS_EN
    check("retired_after_add", retired_count, 32'd1);
`else
    check("retired_after_add", retired_count, 32'd0);
`endif

    // ECALL halt, then 100 cycles of nothing but is_halted
    plan(OP_ECALL, 1'b0, 1'b1, 0, 0, 100);
    check("len_halt", 32'(exp_q.size()), 32'd102);
    run(-1);
    check("halted_sticky", 32'(is_halted), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
